// File: rtl/game_pkg.sv
// Shared definitions for the gravity-runner game: state encoding, playfield
// line heights, grounded player heights and the grounded-test helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [8:0] LINE_TOP = 9'd120;
  localparam logic [8:0] LINE_MID = 9'd240;
  localparam logic [8:0] LINE_BOT = 9'd360;
  localparam logic [8:0] PLAYER_H = 9'd60;

  // The player mover restarts standing on the middle line.
  localparam logic [8:0] START_H = LINE_MID - PLAYER_H;

  // Falling down, the player's feet rest on a line one player height below its top.
  localparam logic [8:0] GND_MID_DOWN = START_H;
  localparam logic [8:0] GND_BOT_DOWN = LINE_BOT - PLAYER_H;
  // Falling up, the player's head presses against the line itself.
  localparam logic [8:0] GND_TOP_UP   = LINE_TOP;
  localparam logic [8:0] GND_MID_UP   = LINE_MID;

  // True when the player is resting on a present line for the current gravity.
  function automatic logic isGrounded(input logic [8:0] h,
                                      input logic [2:0] lines,
                                      input logic       dir);
    if (dir == 1'b0)
      return ((h == GND_MID_DOWN) && lines[1]) || ((h == GND_BOT_DOWN) && lines[2]);
    else
      return ((h == GND_TOP_UP) && lines[0]) || ((h == GND_MID_UP) && lines[1]);
  endfunction

endpackage

// File: rtl/gravity_game_ctrl_tick_divider.sv
// Free-running modulo-DIV counter. The tick output is high during the cycle
// in which an enabled count wraps, so a caller that registers it sees its
// first pulse exactly DIV cycles after the counter was cleared.
module tick_divider #(
  parameter int DIV   = 4,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  import game_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == LAST);
  assign tick   = en & w_wrap;

  // Count while enabled, wrap at DIV-1, and park at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear)
      r_count <= '0;
    else if (en)
      r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
  end

endmodule

// File: rtl/gravity_game_ctrl.sv
// Run controller for the gravity-runner game: game FSM, movement strobe,
// gravity direction, death detection and score keeping.
module gravity_game_ctrl
  import game_pkg::*;
#(
  parameter int MOVE_DIV   = 200000,
  parameter int SCORE_DIV  = 64,
  parameter int DEATH_HOLD = 50000000,
  parameter int MAX_H      = 420,
  parameter int CNT_W      = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        flip_btn,
  input  logic [8:0]  player_height,
  input  logic [2:0]  lines,
  output logic        move_en,
  output logic        grav_dir,
  output logic        is_dead,
  output logic        player_rst_n,
  output logic [15:0] score,
  output logic [1:0]  state
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(SCORE_DIV - 1);
  localparam logic [8:0]       OFF_H     = 9'(MAX_H);

  state_t           r_state, w_nextState;
  logic             r_startQ, r_flipQ;
  logic             r_moveEn, w_nextMoveEn;
  logic             r_gravDir, w_nextGravDir;
  logic             r_isDead, w_nextIsDead;
  logic             r_playerRstN, w_nextPlayerRstN;
  logic [15:0]      r_score, w_nextScore;
  logic [CNT_W-1:0] r_stepCnt, w_nextStepCnt;

  logic w_startRise, w_flipRise, w_grounded, w_offScreen;
  logic w_moveTick, w_holdDone;

  assign w_startRise = start_btn & ~r_startQ;
  assign w_flipRise  = flip_btn & ~r_flipQ;
  assign w_grounded  = isGrounded(player_height, lines, r_gravDir);
  assign w_offScreen = (player_height == 9'd0) || (player_height >= OFF_H);

  // The move divider stops on the death cycle so no strobe leaks into DYING.
  tick_divider #(.DIV(MOVE_DIV), .CNT_W(CNT_W)) u_moveDiv (
    .clk   (clk),
    .reset (reset),
    .clear (r_state != ST_RUN),
    .en    ((r_state == ST_RUN) && !w_offScreen),
    .tick  (w_moveTick)
  );

  tick_divider #(.DIV(DEATH_HOLD), .CNT_W(CNT_W)) u_holdDiv (
    .clk   (clk),
    .reset (reset),
    .clear (r_state != ST_DYING),
    .en    (r_state == ST_DYING),
    .tick  (w_holdDone)
  );

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    w_nextState      = r_state;
    w_nextMoveEn     = 1'b0;
    w_nextGravDir    = r_gravDir;
    w_nextIsDead     = r_isDead;
    w_nextPlayerRstN = r_playerRstN;
    w_nextScore      = r_score;
    w_nextStepCnt    = r_stepCnt;

    case (r_state)
      ST_IDLE: begin
        w_nextPlayerRstN = 1'b0;
        w_nextIsDead     = 1'b0;
        w_nextGravDir    = 1'b0;
        if (w_startRise) begin
          w_nextState      = ST_RUN;
          w_nextScore      = 16'd0;
          w_nextStepCnt    = '0;
          w_nextPlayerRstN = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_moveEn) begin
          if (r_stepCnt == STEP_LAST) begin
            w_nextStepCnt = '0;
            if (r_score != 16'hFFFF)
              w_nextScore = r_score + 16'd1;
          end else begin
            w_nextStepCnt = r_stepCnt + CNT_W'(1);
          end
        end
        if (w_offScreen) begin
          w_nextState  = ST_DYING;
          w_nextIsDead = 1'b1;
        end else begin
          w_nextMoveEn = w_moveTick;
          if (w_flipRise && w_grounded)
            w_nextGravDir = ~r_gravDir;
        end
      end
      ST_DYING: begin
        w_nextIsDead = 1'b1;
        if (w_holdDone)
          w_nextState = ST_OVER;
      end
      ST_OVER: begin
        w_nextIsDead = 1'b1;
        if (w_startRise) begin
          w_nextState      = ST_IDLE;
          w_nextIsDead     = 1'b0;
          w_nextGravDir    = 1'b0;
          w_nextPlayerRstN = 1'b0;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Register FSM state, all outputs and the button edge-detect samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_startQ     <= 1'b0;
      r_flipQ      <= 1'b0;
      r_moveEn     <= 1'b0;
      r_gravDir    <= 1'b0;
      r_isDead     <= 1'b0;
      r_playerRstN <= 1'b0;
      r_score      <= 16'd0;
      r_stepCnt    <= '0;
    end else begin
      r_state      <= w_nextState;
      r_startQ     <= start_btn;
      r_flipQ      <= flip_btn;
      r_moveEn     <= w_nextMoveEn;
      r_gravDir    <= w_nextGravDir;
      r_isDead     <= w_nextIsDead;
      r_playerRstN <= w_nextPlayerRstN;
      r_score      <= w_nextScore;
      r_stepCnt    <= w_nextStepCnt;
    end
  end

  assign move_en      = r_moveEn;
  assign grav_dir     = r_gravDir;
  assign is_dead      = r_isDead;
  assign player_rst_n = r_playerRstN;
  assign score        = r_score;
  assign state        = r_state;

endmodule

// File: tb/tb_gravity_game_ctrl.sv
// Directed bench for gravity_game_ctrl with small timing parameters.
// Expected values are queued when stimulus is applied and compared after
// the following clock edge.
module tb_gravity_game_ctrl;

  localparam int SEL_STATE = 0;
  localparam int SEL_MOVE  = 1;
  localparam int SEL_GRAV  = 2;
  localparam int SEL_DEAD  = 3;
  localparam int SEL_RSTN  = 4;
  localparam int SEL_SCORE = 5;

  typedef struct {
    string tag;
    int    sel;
    int    value;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        startBtn;
  logic        flipBtn;
  logic [8:0]  playerHeight;
  logic [2:0]  lines;
  logic        moveEn;
  logic        gravDir;
  logic        isDead;
  logic        playerRstN;
  logic [15:0] score;
  logic [1:0]  state;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   runEdges = 0;
  int   frozenScore;

  gravity_game_ctrl #(
    .MOVE_DIV   (4),
    .SCORE_DIV  (2),
    .DEATH_HOLD (8),
    .MAX_H      (420),
    .CNT_W      (27)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_btn     (startBtn),
    .flip_btn      (flipBtn),
    .player_height (playerHeight),
    .lines         (lines),
    .move_en       (moveEn),
    .grav_dir      (gravDir),
    .is_dead       (isDead),
    .player_rst_n  (playerRstN),
    .score         (score),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int observe(input int sel);
    case (sel)
      SEL_STATE: return int'(state);
      SEL_MOVE:  return int'(moveEn);
      SEL_GRAV:  return int'(gravDir);
      SEL_DEAD:  return int'(isDead);
      SEL_RSTN:  return int'(playerRstN);
      default:   return int'(score);
    endcase
  endfunction

  task automatic applyStimulus(input logic start, input logic flip,
                               input int h, input logic [2:0] ln);
    startBtn     = start;
    flipBtn      = flip;
    playerHeight = 9'(h);
    lines        = ln;
  endtask

  task automatic expectVal(input string tag, input int sel, input int value);
    exp_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    int   obs;
    while (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic clockStep();
    @(posedge clk);
    runEdges++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic expectResetValues(input string tag);
    expectVal({tag, "_state"}, SEL_STATE, 0);
    expectVal({tag, "_move"},  SEL_MOVE,  0);
    expectVal({tag, "_grav"},  SEL_GRAV,  0);
    expectVal({tag, "_dead"},  SEL_DEAD,  0);
    expectVal({tag, "_rstn"},  SEL_RSTN,  0);
    expectVal({tag, "_score"}, SEL_SCORE, 0);
  endtask

  initial begin
    // Reset for two cycles.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 180, 3'b000);
    clockStep();
    expectResetValues("reset");
    clockStep();
    reset = 1'b0;
    expectResetValues("idle");
    clockStep();

    // Start a run.
    applyStimulus(1'b1, 1'b0, 180, 3'b000);
    expectVal("start_state", SEL_STATE, 1);
    expectVal("start_rstn",  SEL_RSTN,  1);
    expectVal("start_move",  SEL_MOVE,  0);
    expectVal("start_score", SEL_SCORE, 0);
    clockStep();
    runEdges = 0;
    applyStimulus(1'b0, 1'b0, 180, 3'b000);

    // Movement strobe every 4th edge; score steps every 2nd strobe.
    for (int k = 1; k <= 26; k++) begin
      expectVal($sformatf("move_k%0d", k),  SEL_MOVE,  (k % 4 == 0) ? 1 : 0);
      expectVal($sformatf("score_k%0d", k), SEL_SCORE, (k - 1) / 8);
      clockStep();
    end

    // Grounded flip toggles gravity up.
    applyStimulus(1'b0, 1'b1, 180, 3'b010);
    expectVal("flip_grounded", SEL_GRAV, 1);
    clockStep();
    applyStimulus(1'b0, 1'b0, 180, 3'b010);
    expectVal("flip_release", SEL_GRAV, 1);
    clockStep();

    // Airborne flip is ignored.
    applyStimulus(1'b0, 1'b1, 200, 3'b010);
    expectVal("flip_airborne", SEL_GRAV, 1);
    clockStep();
    applyStimulus(1'b0, 1'b0, 200, 3'b010);
    clockStep();

    // Held flip toggles only once even while grounded afterwards.
    applyStimulus(1'b0, 1'b1, 240, 3'b010);
    expectVal("flip_held_first", SEL_GRAV, 0);
    clockStep();
    applyStimulus(1'b0, 1'b1, 180, 3'b010);
    for (int k = 0; k < 9; k++) begin
      expectVal($sformatf("flip_held_%0d", k), SEL_GRAV, 0);
      clockStep();
    end
    applyStimulus(1'b0, 1'b0, 180, 3'b010);
    while (((runEdges + 1) % 8) != 3) clockStep();

    // Fall off the bottom.
    frozenScore = runEdges / 8;
    applyStimulus(1'b0, 1'b0, 420, 3'b010);
    expectVal("death_state", SEL_STATE, 2);
    expectVal("death_dead",  SEL_DEAD,  1);
    expectVal("death_move",  SEL_MOVE,  0);
    expectVal("death_score", SEL_SCORE, frozenScore);
    clockStep();
    for (int j = 1; j <= 7; j++) begin
      expectVal($sformatf("dying_state_%0d", j), SEL_STATE, 2);
      expectVal($sformatf("dying_score_%0d", j), SEL_SCORE, frozenScore);
      expectVal($sformatf("dying_move_%0d", j),  SEL_MOVE,  0);
      clockStep();
      if (j == 2) applyStimulus(1'b1, 1'b0, 420, 3'b010);
      if (j == 3) applyStimulus(1'b0, 1'b0, 420, 3'b010);
    end
    expectVal("over_state", SEL_STATE, 3);
    expectVal("over_dead",  SEL_DEAD,  1);
    expectVal("over_score", SEL_SCORE, frozenScore);
    expectVal("over_rstn",  SEL_RSTN,  1);
    clockStep();

    // Restart: OVER -> IDLE -> RUN.
    applyStimulus(1'b1, 1'b0, 420, 3'b010);
    expectVal("restart_state", SEL_STATE, 0);
    expectVal("restart_dead",  SEL_DEAD,  0);
    expectVal("restart_grav",  SEL_GRAV,  0);
    expectVal("restart_rstn",  SEL_RSTN,  0);
    clockStep();
    applyStimulus(1'b0, 1'b0, 180, 3'b010);
    clockStep();
    applyStimulus(1'b1, 1'b0, 180, 3'b010);
    expectVal("run2_state", SEL_STATE, 1);
    expectVal("run2_score", SEL_SCORE, 0);
    expectVal("run2_rstn",  SEL_RSTN,  1);
    clockStep();
    applyStimulus(1'b0, 1'b1, 180, 3'b010);
    expectVal("run2_flip", SEL_GRAV, 1);
    clockStep();
    applyStimulus(1'b0, 1'b0, 180, 3'b010);
    clockStep();

    // Height 0 together with a flip edge: death wins, gravity holds.
    applyStimulus(1'b0, 1'b1, 0, 3'b111);
    expectVal("top_death_state", SEL_STATE, 2);
    expectVal("top_death_grav",  SEL_GRAV,  1);
    expectVal("top_death_dead",  SEL_DEAD,  1);
    clockStep();
    applyStimulus(1'b0, 1'b0, 0, 3'b111);
    for (int j = 1; j <= 7; j++) clockStep();
    expectVal("top_over_state", SEL_STATE, 3);
    expectVal("top_over_grav",  SEL_GRAV,  1);
    clockStep();

    // Third run, then reset while a strobe is in flight.
    applyStimulus(1'b1, 1'b0, 180, 3'b010);
    expectVal("run3_idle", SEL_STATE, 0);
    clockStep();
    applyStimulus(1'b0, 1'b0, 180, 3'b010);
    clockStep();
    applyStimulus(1'b1, 1'b0, 180, 3'b010);
    expectVal("run3_state", SEL_STATE, 1);
    clockStep();
    runEdges = 0;
    applyStimulus(1'b0, 1'b1, 180, 3'b010);
    expectVal("run3_flip", SEL_GRAV, 1);
    clockStep();
    applyStimulus(1'b0, 1'b0, 180, 3'b010);
    while (runEdges < 11) clockStep();
    expectVal("run3_move",  SEL_MOVE,  1);
    expectVal("run3_score", SEL_SCORE, 1);
    clockStep();
    reset = 1'b1;
    expectResetValues("midrun_reset");
    clockStep();
    reset = 1'b0;
    expectVal("post_reset_state", SEL_STATE, 0);
    expectVal("post_reset_move",  SEL_MOVE,  0);
    clockStep();

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
